// File: rtl/mem_writeback_buffer_if.sv
// Write-back request and memory drain bundle for mem_writeback_buffer.
// The slave modport is the buffer's view; master is the sources/memory view.
interface mem_writeback_buffer_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic [3:0]        wr_valid;
  logic [ADDR_W-1:0] wr_addr0;
  logic [ADDR_W-1:0] wr_addr1;
  logic [ADDR_W-1:0] wr_addr2;
  logic [ADDR_W-1:0] wr_addr3;
  logic [DATA_W-1:0] wr_data0;
  logic [DATA_W-1:0] wr_data1;
  logic [DATA_W-1:0] wr_data2;
  logic [DATA_W-1:0] wr_data3;
  logic              wb_stall;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport slave (
    input  wr_valid, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
    input  wr_data0, wr_data1, wr_data2, wr_data3, mem_ready,
    output wb_stall, mem_we, mem_addr, mem_data
  );

  modport master (
    output wr_valid, wr_addr0, wr_addr1, wr_addr2, wr_addr3,
    output wr_data0, wr_data1, wr_data2, wr_data3, mem_ready,
    input  wb_stall, mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/mem_writeback_buffer.sv
// Posted write-back FIFO: merges four write streams in source order, drains one
// word per cycle to memory, and forwards the youngest pending data to two readers.
module mem_writeback_buffer #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  mem_writeback_buffer_if.slave    wb,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic                     fwd_hit1,
  output logic [DATA_W-1:0]        fwd_data1,
  output logic                     fwd_hit2,
  output logic [DATA_W-1:0]        fwd_data2,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] STALL_THR = CNT_W'(DEPTH - 4);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            fifo_q [DEPTH];
  entry_t            fifo_d [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] src_addr [4];
  logic [DATA_W-1:0] src_data [4];
  logic [2:0]        n_enq;
  logic              pop;

  assign src_addr[0] = wb.wr_addr0;
  assign src_addr[1] = wb.wr_addr1;
  assign src_addr[2] = wb.wr_addr2;
  assign src_addr[3] = wb.wr_addr3;
  assign src_data[0] = wb.wr_data0;
  assign src_data[1] = wb.wr_data1;
  assign src_data[2] = wb.wr_data2;
  assign src_data[3] = wb.wr_data3;

  // Stall whenever fewer than four slots are free, so a full burst always fits.
  assign wb.wb_stall = (count_q > STALL_THR);
  assign pop         = (count_q != '0) && wb.mem_ready;

  // Pack asserted sources contiguously from the write pointer, lowest index first.
  always_comb begin : enqueue
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    fifo_d = fifo_q;
    n_enq  = '0;
    if (!wb.wb_stall) begin
      for (int s = 0; s < 4; s++) begin
        if (wb.wr_valid[s]) begin
          fifo_d[wr_ptr_q + PTR_W'(n_enq)] = '{addr: src_addr[s], data: src_data[s]};
          n_enq = n_enq + 3'd1;
        end
      end
    end
  end

  always_comb begin : state_next
    count_d    = count_q + CNT_W'(n_enq) - CNT_W'(pop);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_enq);
    overflow_d = overflow_q | (wb.wb_stall & (|wb.wr_valid));
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  assign wb.mem_we   = (count_q != '0);
  assign wb.mem_addr = wb.mem_we ? fifo_q[rd_ptr_q].addr : '0;
  assign wb.mem_data = wb.mem_we ? fifo_q[rd_ptr_q].data : '0;
  assign occupancy   = count_q;
  assign overflow    = overflow_q;

  // Walk live entries oldest to youngest; a later match overrides, leaving the youngest.
  always_comb begin : forward
    logic [PTR_W-1:0] slot;
    slot      = '0;
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q + PTR_W'(i);
      if (CNT_W'(i) < count_q) begin
        if (fifo_q[slot].addr == rd_addr1) begin
          fwd_hit1  = 1'b1;
          fwd_data1 = fifo_q[slot].data;
        end
        if (fifo_q[slot].addr == rd_addr2) begin
          fwd_hit2  = 1'b1;
          fwd_data2 = fifo_q[slot].data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_writeback_buffer.sv
// Directed self-checking bench for mem_writeback_buffer: reset, drain order,
// backpressure/overflow, forwarding and same-cycle address conflicts.
module tb_mem_writeback_buffer;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2;
  logic              fwd_hit1, fwd_hit2;
  logic [DATA_W-1:0] fwd_data1, fwd_data2;
  logic [3:0]        occupancy;
  logic              overflow;

  int checks = 0;
  int errors = 0;

  mem_writeback_buffer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wb_if ();

  mem_writeback_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb_if.slave),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .occupancy (occupancy),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int idx, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_if.wr_valid[idx] = 1'b1;
    case (idx)
      0: begin wb_if.wr_addr0 = a; wb_if.wr_data0 = d; end
      1: begin wb_if.wr_addr1 = a; wb_if.wr_data1 = d; end
      2: begin wb_if.wr_addr2 = a; wb_if.wr_data2 = d; end
      default: begin wb_if.wr_addr3 = a; wb_if.wr_data3 = d; end
    endcase
  endtask

  task automatic clear_wr();
    wb_if.wr_valid = 4'b0000;
    wb_if.wr_addr0 = '0; wb_if.wr_addr1 = '0; wb_if.wr_addr2 = '0; wb_if.wr_addr3 = '0;
    wb_if.wr_data0 = '0; wb_if.wr_data1 = '0; wb_if.wr_data2 = '0; wb_if.wr_data3 = '0;
  endtask

  initial begin
    rst_n           = 1'b0;
    wb_if.mem_ready = 1'b0;
    rd_addr1        = '0;
    rd_addr2        = '0;
    clear_wr();
    step();
    step();

    // Reset state
    check("rst_occ",      occupancy,      0);
    check("rst_mem_we",   wb_if.mem_we,   0);
    check("rst_stall",    wb_if.wb_stall, 0);
    check("rst_overflow", overflow,       0);
    check("rst_mem_addr", wb_if.mem_addr, 0);
    rst_n = 1'b1;
    step();

    // Test 1: reset with three entries pending
    set_wr(0, 9'h030, 32'h30);
    set_wr(1, 9'h031, 32'h31);
    set_wr(2, 9'h032, 32'h32);
    step();
    clear_wr();
    check("t1_occ_before", occupancy,    3);
    check("t1_we_before",  wb_if.mem_we, 1);
    rd_addr1 = 9'h030;
    rst_n    = 1'b0;
    #1;
    check("t1_occ_rst",  occupancy,    0);
    check("t1_we_rst",   wb_if.mem_we, 0);
    check("t1_ovf_rst",  overflow,     0);
    check("t1_hit1_rst", fwd_hit1,     0);
    check("t1_fwd1_rst", fwd_data1,    0);
    step();
    rst_n           = 1'b1;
    wb_if.mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t1_no_write", wb_if.mem_we, 0);
    end

    // Test 2: single write, one-cycle latency
    set_wr(0, 9'h005, 32'hDEADBEEF);
    step();
    clear_wr();
    check("t2_we",   wb_if.mem_we,   1);
    check("t2_addr", wb_if.mem_addr, 9'h005);
    check("t2_data", wb_if.mem_data, 32'hDEADBEEF);
    check("t2_occ",  occupancy,      1);
    step();
    check("t2_we_after", wb_if.mem_we, 0);
    check("t2_occ_after", occupancy,   0);

    // Test 3: four simultaneous writes drain in source order
    for (int s = 0; s < 4; s++) set_wr(s, ADDR_W'(s + 1), DATA_W'(32'h100 + s));
    step();
    clear_wr();
    check("t3_stall_at4", wb_if.wb_stall, 0);
    for (int i = 0; i < 4; i++) begin
      check("t3_occ",  occupancy,      4 - i);
      check("t3_addr", wb_if.mem_addr, i + 1);
      check("t3_data", wb_if.mem_data, 32'h100 + i);
      step();
    end
    check("t3_occ_end", occupancy,    0);
    check("t3_we_end",  wb_if.mem_we, 0);

    // Test 4: backpressure, stall and dropped request
    wb_if.mem_ready = 1'b0;
    for (int s = 0; s < 4; s++) set_wr(s, ADDR_W'(9'h040 + s), DATA_W'(32'h400 + s));
    step();
    clear_wr();
    check("t4_occ4",   occupancy,      4);
    check("t4_stall4", wb_if.wb_stall, 0);
    set_wr(0, 9'h044, 32'h404);
    step();
    clear_wr();
    check("t4_occ5",   occupancy,      5);
    check("t4_stall5", wb_if.wb_stall, 1);
    check("t4_ovf0",   overflow,       0);
    set_wr(1, 9'h045, 32'h405);
    step();
    clear_wr();
    check("t4_occ_drop", occupancy, 5);
    check("t4_ovf1",     overflow,  1);
    wb_if.mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t4_we",   wb_if.mem_we,   1);
      check("t4_addr", wb_if.mem_addr, 9'h040 + i);
      check("t4_data", wb_if.mem_data, 32'h400 + i);
      step();
    end
    check("t4_we_end",  wb_if.mem_we, 0);
    check("t4_ovf_end", overflow,     1);

    // Test 5: forwarding returns the youngest matching entry
    wb_if.mem_ready = 1'b0;
    rd_addr1 = 9'h010;
    rd_addr2 = 9'h011;
    set_wr(0, 9'h010, 32'hA);
    step();
    clear_wr();
    check("t5_hit1_one",  fwd_hit1,  1);
    check("t5_data1_one", fwd_data1, 32'hA);
    set_wr(0, 9'h010, 32'hB);
    step();
    clear_wr();
    check("t5_hit1",  fwd_hit1,  1);
    check("t5_data1", fwd_data1, 32'hB);
    check("t5_hit2",  fwd_hit2,  0);
    check("t5_data2", fwd_data2, 0);
    wb_if.mem_ready = 1'b1;
    step();
    check("t5_hit1_mid",  fwd_hit1,  1);
    check("t5_data1_mid", fwd_data1, 32'hB);
    step();
    check("t5_hit1_end", fwd_hit1, 0);

    // Test 6: same address from sources 0 and 3 in one cycle
    wb_if.mem_ready = 1'b0;
    rd_addr1 = 9'h020;
    rd_addr2 = 9'h020;
    set_wr(0, 9'h020, 32'd1);
    set_wr(3, 9'h020, 32'd2);
    step();
    clear_wr();
    check("t6_occ",   occupancy, 2);
    check("t6_fwd1",  fwd_data1, 32'd2);
    check("t6_fwd2",  fwd_data2, 32'd2);
    wb_if.mem_ready = 1'b1;
    check("t6_first", wb_if.mem_data, 32'd1);
    step();
    check("t6_second",   wb_if.mem_data, 32'd2);
    check("t6_fwd_mid",  fwd_data1,      32'd2);
    step();
    check("t6_we_end",   wb_if.mem_we, 0);
    check("t6_hit_end",  fwd_hit1,     0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
